// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SIGNEXT = 2'b10;
    localparam logic [1:0] SRCB_SHIFT   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory handshake and are guarded by the timer.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; timeout_o rises once MEM_TIMEOUT stalls have elapsed.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign timeout_o = (cnt_q == CW'(MEM_TIMEOUT));

    // Next count: clear has priority, and the count saturates at the timeout value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !timeout_o) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS datapath: sequences fetch/decode/execute one state
// per cycle, drives every select and enable, and traps on illegal opcodes or memory timeouts.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal,
    output logic               mem_err,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state
);
    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               in_wait_s, expired_s, stall_s, timeout_s;

    // A mem_ready arriving in the expiry cycle still completes the access normally.
    assign in_wait_s = is_wait_state(state_q);
    assign stall_s   = in_wait_s & ~mem_ready & ~expired_s;
    assign timeout_s = in_wait_s & ~mem_ready & expired_s;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (~stall_s),
        .inc_i    (stall_s),
        .timeout_o(expired_s)
    );

    // Next-state, trap-cause and retire-count logic.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
                else     state_d = S_IDLE;
            end
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (expired_s) state_d = S_TRAP;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                 state_d = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready)      state_d = S_MEM_WB;
                else if (expired_s) state_d = S_TRAP;
                else                state_d = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready)      state_d = run ? S_FETCH : S_IDLE;
                else if (expired_s) state_d = S_TRAP;
                else                state_d = S_MEM_WRITE;
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_EXECUTE: state_d = S_ALU_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_TRAP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (instr_done) count_d = count_q + COUNT_W'(1);
        else            count_d = count_q;
    end

    // Moore decode of the current state, with handshake-qualified strobes.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        mem_err     = timeout_s;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = SRCB_SHIFT;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SIGNEXT;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = ~timeout_s;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SIGNEXT;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  illegal = illegal_q;
            default: mem_err = 1'b0;
        endcase
    end

    // State, trap cause and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle variant of the MIPS datapath: shared instruction/data memory, IR latch, ALU reused for PC+4 and branch target.
- Decodes opcode from the latched IR and drives every datapath select and write enable, one state per cycle.
- Waits on a memory ready handshake, with a timeout.
- Counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles any memory state waits for mem_ready before trapping (must be >= 1).
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  permits fetch of the next instruction.
- opcode  in  6  IR[31:26] from the latched instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write qualified by ALU Zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  latch instruction register.
- MemToReg  out  1  register write data select: 1 = MDR.
- RegDst  out  1  write register select: 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU operand B select: 00 rt, 01 const 4, 10 SignExtImm, 11 ShiftLeftImm.
- ALUOp  out  2  to ALUControl: 00 add, 01 sub, 10 funct.
- PCSource  out  2  PC source select: 00 ALU, 01 ALUOut, 10 jump target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- instr_count  out  COUNT_W  retired-instruction count.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=13. Codes 14 and 15 go to IDLE on the next cycle.
- Reset (rst_n=0 at a rising edge): state=IDLE, instr_count=0, wait counter=0. In IDLE every output is 0.
- Asserting rst_n=0 in any state, including mid memory wait, returns to IDLE on the next edge. No write enable is asserted in that cycle's outputs after the edge.
- IDLE: go to FETCH if run=1, else stay.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are 1 only in the cycle mem_ready=1; that cycle the FSM goes to DECODE.
  - Otherwise stay and hold all outputs stable.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> ADDI_EX.
  - Any other opcode -> TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for mem_ready; instruction retires in the cycle mem_ready=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALU_WB.
- ALU_WB: RegWrite=1, RegDst=1, MemToReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0.
- Retiring states (MEM_WB, MEM_WRITE with mem_ready=1, ALU_WB, BRANCH, JUMP, ADDI_WB):
  - instr_done=1 that cycle.
  - instr_count increments at the edge, wrapping modulo 2^COUNT_W.
  - Next state is FETCH if run=1, else IDLE.
- Memory wait states (FETCH, MEM_READ, MEM_WRITE):
  - The wait counter clears on entry and increments each cycle mem_ready=0.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP, mem_err=1 for that cycle, and assert no write enable.
  - mem_ready=1 on the same cycle as the timeout wins: normal completion.
- TRAP: illegal=1 if entered from DECODE; no write enables asserted. Next state is IDLE; software or the bench must re-assert run to resume. Illegal instructions never increment instr_count.
- Deasserting run does not abort an in-flight instruction; it only blocks the next FETCH.
- Latencies in cycles from FETCH entry, with zero-wait memory: R-type 4, addi 4, beq 3, j 3, sw 4, lw 5.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (4-bit localparams);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp codes;
  - ALUSrcB codes;
  - PCSource codes.
- One sub-module, mem_wait_timer: wait counter with clear, increment and timeout flag, parameterised by MEM_TIMEOUT.
- Next-state and output decode stay in multicycle_control.

Test Plan:
- Reset with run=0 -> state=0, all outputs 0, instr_count=0. Raise run -> FETCH next cycle with MemRead=1, IorD=0.
- Zero-wait sequence of R-type, lw, sw, beq, j, addi with run=1 -> state traces of 4, 5, 4, 3, 3, 4 cycles; instr_count=6; exactly six instr_done pulses.
- lw with mem_ready low for 3 cycles in MEM_READ -> MemRead/IorD held for 4 cycles, then MEM_WB; no RegWrite during the wait.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> mem_err pulses once, then TRAP, then IDLE; PCWrite and IRWrite never asserted; instr_count unchanged.
- opcode=111111 in DECODE -> TRAP with illegal=1 for one cycle, then IDLE; no RegWrite, MemWrite or PCWrite.
- rst_n=0 during MEM_WRITE wait -> IDLE next cycle, MemWrite=0, instr_count=0. COUNT_W=4 with 17 retirements -> instr_count=1.
